// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic en_PC;
    logic en_IFID;
    logic en_IDEX;
    logic en_ExMem;
    logic en_MemWB;
    logic flush_IFID;
    logic flush_IDEX;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam stage_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam stage_ctrl_t CTRL_BRANCH = 7'b11111_11;
  localparam stage_ctrl_t CTRL_LDUSE  = 7'b00111_01;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory handshake tracker: wait state, timeout counter and sticky error.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk_Stall,
  input  logic rstn_Stall,
  input  logic dmem_req_Mem,
  input  logic dmem_ready_Mem,
  output logic mem_stall,
  output logic mem_wait,
  output logic mem_err
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_err_q, mem_err_d;

  always_ff @(posedge clk_Stall or negedge rstn_Stall) begin
    if (!rstn_Stall) begin
      state_q   <= MEM_IDLE;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    mem_err_d = mem_err_q;
    mem_stall = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        // A same-cycle ready completes with no stall at all.
        if (dmem_req_Mem && !dmem_ready_Mem) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          to_cnt_d  = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_Mem) begin
          state_d  = MEM_IDLE;
          to_cnt_d = '0;
        end else begin
          mem_stall = 1'b1;
          to_cnt_d  = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_LAST) begin
            state_d   = MEM_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      MEM_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  assign mem_wait = (state_q == MEM_WAIT);
  assign mem_err  = mem_err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall sequencer: per-stage enables and bubbles from load-use,
// taken-branch and data-memory wait sources, plus a saturating stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_Stall,
  input  logic             rstn_Stall,
  input  logic [4:0]       rs1_addr_ID,
  input  logic [4:0]       rs2_addr_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       Rd_addr_EX,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_Mem,
  input  logic             dmem_ready_Mem,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_ExMem,
  output logic             en_MemWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             mem_wait,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic        mem_stall;
  logic        load_use;
  logic        count_stall;
  stage_ctrl_t ctrl_c;
  stage_ctrl_t ctrl_out;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk_Stall     (clk_Stall),
    .rstn_Stall    (rstn_Stall),
    .dmem_req_Mem  (dmem_req_Mem),
    .dmem_ready_Mem(dmem_ready_Mem),
    .mem_stall     (mem_stall),
    .mem_wait      (mem_wait),
    .mem_err       (mem_err)
  );

  assign load_use = MemRead_EX && RegWrite_EX && (Rd_addr_EX != REG_ZERO) &&
                    ((rs1_used_ID && (Rd_addr_EX == rs1_addr_ID)) ||
                     (rs2_used_ID && (Rd_addr_EX == rs2_addr_ID)));

  // A frozen EX stage keeps branch/load-use inputs stable, so deferring them
  // under a memory stall simply re-evaluates them in the release cycle.
  always_comb begin
    ctrl_c      = CTRL_RUN;
    count_stall = 1'b0;
    if (mem_stall) begin
      ctrl_c      = CTRL_FREEZE;
      count_stall = 1'b1;
    end else if (branch_taken_EX) begin
      ctrl_c = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl_c      = CTRL_LDUSE;
      count_stall = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (count_stall) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
  end

  always_ff @(posedge clk_Stall or negedge rstn_Stall) begin
    if (!rstn_Stall) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // While reset is held the pipeline runs free regardless of hazard inputs.
  assign ctrl_out = rstn_Stall ? ctrl_c : CTRL_RUN;

  assign en_PC        = ctrl_out.en_PC;
  assign en_IFID      = ctrl_out.en_IFID;
  assign en_IDEX      = ctrl_out.en_IDEX;
  assign en_ExMem     = ctrl_out.en_ExMem;
  assign en_MemWB     = ctrl_out.en_MemWB;
  assign flush_IFID   = ctrl_out.flush_IFID;
  assign flush_IDEX   = ctrl_out.flush_IDEX;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expectations,
// a monitor pops and compares them on the falling edge of each cycle.
module tb_pipe_stall_ctrl;

  localparam logic [6:0] RUN = 7'b11111_00;
  localparam logic [6:0] FRZ = 7'b00000_00;
  localparam logic [6:0] BRN = 7'b11111_11;
  localparam logic [6:0] LDU = 7'b00111_01;

  logic        clk_Stall = 1'b0;
  logic        rstn_Stall = 1'b0;
  logic [4:0]  rs1_addr_ID = '0, rs2_addr_ID = '0, Rd_addr_EX = '0;
  logic        rs1_used_ID = 1'b0, rs2_used_ID = 1'b0;
  logic        MemRead_EX = 1'b0, RegWrite_EX = 1'b0, branch_taken_EX = 1'b0;
  logic        dmem_req_Mem = 1'b0, dmem_ready_Mem = 1'b0;
  logic        en_PC, en_IFID, en_IDEX, en_ExMem, en_MemWB, flush_IFID, flush_IDEX;
  logic        mem_wait, mem_err;
  logic [15:0] stall_cycles;

  typedef struct {
    string       name;
    logic [6:0]  ctrl;
    logic        mw;
    logic        me;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_Stall      (clk_Stall),
    .rstn_Stall     (rstn_Stall),
    .rs1_addr_ID    (rs1_addr_ID),
    .rs2_addr_ID    (rs2_addr_ID),
    .rs1_used_ID    (rs1_used_ID),
    .rs2_used_ID    (rs2_used_ID),
    .Rd_addr_EX     (Rd_addr_EX),
    .MemRead_EX     (MemRead_EX),
    .RegWrite_EX    (RegWrite_EX),
    .branch_taken_EX(branch_taken_EX),
    .dmem_req_Mem   (dmem_req_Mem),
    .dmem_ready_Mem (dmem_ready_Mem),
    .en_PC          (en_PC),
    .en_IFID        (en_IFID),
    .en_IDEX        (en_IDEX),
    .en_ExMem       (en_ExMem),
    .en_MemWB       (en_MemWB),
    .flush_IFID     (flush_IFID),
    .flush_IDEX     (flush_IDEX),
    .mem_wait       (mem_wait),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk_Stall = ~clk_Stall;

  // Monitor: outputs are valid every cycle, compare whenever an expectation is pending.
  always @(negedge clk_Stall) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {en_PC, en_IFID, en_IDEX, en_ExMem, en_MemWB, flush_IFID, flush_IDEX};
      n_total++;
      if (act === e.ctrl && mem_wait === e.mw && mem_err === e.me && stall_cycles === e.sc) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ctrl=%b mw=%b me=%b sc=%h, want ctrl=%b mw=%b me=%b sc=%h",
                 e.name, act, mem_wait, mem_err, stall_cycles, e.ctrl, e.mw, e.me, e.sc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_Stall);
    #1;
  endtask

  task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic rw, input logic br,
                       input logic req, input logic rdy);
    rs1_addr_ID = r1;  rs1_used_ID = u1;
    rs2_addr_ID = r2;  rs2_used_ID = u2;
    Rd_addr_EX  = rd;  MemRead_EX  = mr;  RegWrite_EX = rw;
    branch_taken_EX = br;
    dmem_req_Mem = req; dmem_ready_Mem = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string n, input logic [6:0] c, input logic mw, input logic me,
                      input logic [15:0] sc);
    exp_t e;
    e.name = n; e.ctrl = c; e.mw = mw; e.me = me; e.sc = sc;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk_Stall);
    // Reset overrides hazard and memory-stall conditions.
    cyc(); drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push("reset_outputs", RUN, 1'b0, 1'b0, 16'd0);
    cyc(); rstn_Stall = 1'b1; idle();
    push("idle_after_reset", RUN, 1'b0, 1'b0, 16'd0);

    // Load-use hazards and non-hazards.
    cyc(); drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_use_rs1", LDU, 1'b0, 1'b0, 16'd0);
    cyc(); idle();
    push("after_load_use", RUN, 1'b0, 1'b0, 16'd1);
    cyc(); drive(5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rd_x0_no_stall", RUN, 1'b0, 1'b0, 16'd1);
    cyc(); drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rs2_unused_no_stall", RUN, 1'b0, 1'b0, 16'd1);
    cyc(); drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("load_use_rs2", LDU, 1'b0, 1'b0, 16'd1);
    cyc(); drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push("branch_over_load_use", BRN, 1'b0, 1'b0, 16'd2);
    cyc(); idle();
    push("after_branch", RUN, 1'b0, 1'b0, 16'd2);

    // Memory wait of three cycles released on the fourth.
    cyc(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("mem_wait_c1", FRZ, 1'b0, 1'b0, 16'd2);
    cyc(); push("mem_wait_c2", FRZ, 1'b1, 1'b0, 16'd3);
    cyc(); push("mem_wait_c3", FRZ, 1'b1, 1'b0, 16'd4);
    cyc(); dmem_ready_Mem = 1'b1;
    push("mem_release", RUN, 1'b1, 1'b0, 16'd5);
    cyc(); idle();
    push("mem_idle_again", RUN, 1'b0, 1'b0, 16'd5);
    cyc(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    push("same_cycle_ready", RUN, 1'b0, 1'b0, 16'd5);
    cyc(); idle();
    push("no_wait_after_fast", RUN, 1'b0, 1'b0, 16'd5);

    // Branch deferred while memory stalls.
    cyc(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("defer_branch_c1", FRZ, 1'b0, 1'b0, 16'd5);
    cyc(); push("defer_branch_c2", FRZ, 1'b1, 1'b0, 16'd6);
    cyc(); dmem_ready_Mem = 1'b1;
    push("deferred_branch_release", BRN, 1'b1, 1'b0, 16'd7);
    cyc(); idle();
    push("after_deferred", RUN, 1'b0, 1'b0, 16'd7);

    // Timeout into sticky error.
    cyc(); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("to_c1", FRZ, 1'b0, 1'b0, 16'd7);
    cyc(); push("to_c2", FRZ, 1'b1, 1'b0, 16'd8);
    cyc(); push("to_c3", FRZ, 1'b1, 1'b0, 16'd9);
    cyc(); push("to_c4", FRZ, 1'b1, 1'b0, 16'd10);
    cyc(); dmem_req_Mem = 1'b0; dmem_ready_Mem = 1'b1;
    push("mem_err_set", FRZ, 1'b0, 1'b1, 16'd11);
    cyc(); push("mem_err_sticky", FRZ, 1'b0, 1'b1, 16'd12);

    // Prolonged error stall drives the counter into saturation.
    repeat (65540) @(posedge clk_Stall);
    #1;
    push("stall_cnt_saturated", FRZ, 1'b0, 1'b1, 16'hFFFF);

    // Asynchronous reset mid-cycle restores reset outputs at once.
    cyc(); #2; rstn_Stall = 1'b0; dmem_req_Mem = 1'b1; dmem_ready_Mem = 1'b0;
    push("async_reset_clears", RUN, 1'b0, 1'b0, 16'd0);
    cyc(); rstn_Stall = 1'b1; idle();
    push("run_after_reset", RUN, 1'b0, 1'b0, 16'd0);

    @(negedge clk_Stall);
    @(negedge clk_Stall);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard/stall sequencer for the 5-stage pipeline (IF/ID, ID/EX, Ex/Mem, Mem/WB registers plus PC).
- Generates per-stage enables and flush (bubble) requests from three sources: load-use data hazards, taken branches/jumps resolved in EX, and a multi-cycle data-memory handshake.
- Tracks memory-wait state, enforces a timeout, and keeps a saturating stall-cycle counter for debug.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering MEM_ERR (must be ≥2).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk_Stall  in  1  pipeline clock.
- rstn_Stall  in  1  asynchronous active-low reset.
- rs1_addr_ID  in  5  rs1 field of the instruction in ID.
- rs2_addr_ID  in  5  rs2 field of the instruction in ID.
- rs1_used_ID  in  1  instruction in ID reads rs1.
- rs2_used_ID  in  1  instruction in ID reads rs2.
- Rd_addr_EX  in  5  destination of the instruction in EX.
- MemRead_EX  in  1  instruction in EX is a load.
- RegWrite_EX  in  1  instruction in EX writes a register.
- branch_taken_EX  in  1  taken branch/jump resolved in EX this cycle.
- dmem_req_Mem  in  1  the instruction in Mem accesses data memory.
- dmem_ready_Mem  in  1  data memory completes the access this cycle.
- en_PC  out  1  PC update enable.
- en_IFID, en_IDEX, en_ExMem, en_MemWB  out  1 each  pipeline register enables.
- flush_IFID, flush_IDEX  out  1 each  synchronous bubble request; the register clears on the next edge.
- mem_wait  out  1  FSM is in MEM_WAIT.
- mem_err  out  1  sticky timeout error.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rstn_Stall=0, asynchronous):
  - FSM=MEM_IDLE; timeout counter=0; stall_cycles=0; mem_err=0.
  - Outputs while in reset: all en_*=1, flushes=0.
- Combinational terms:
  - load_use = MemRead_EX & RegWrite_EX & (Rd_addr_EX!=0) & ((rs1_used_ID & Rd_addr_EX==rs1_addr_ID) | (rs2_used_ID & Rd_addr_EX==rs2_addr_ID)).
  - mem_stall = (state==MEM_IDLE & dmem_req_Mem & !dmem_ready_Mem) | (state==MEM_WAIT & !dmem_ready_Mem) | (state==MEM_ERR).
- Priority 1, mem_stall:
  - All en_*=0; flush_*=0.
  - Pending branch/load-use is deferred. EX inputs are frozen, so it re-evaluates on release.
  - Freezing Mem/WB repeats an idempotent writeback.
- Priority 2, branch_taken_EX:
  - flush_IFID=1, flush_IDEX=1; all en_*=1.
  - load_use is ignored because the ID instruction is discarded.
- Priority 3, load_use:
  - en_PC=0, en_IFID=0, flush_IDEX=1; en_IDEX=en_ExMem=en_MemWB=1.
  - Exactly one bubble per load-use pair.
- Otherwise: all en_*=1, flushes=0.
- FSM, state updates on rising clk_Stall:
  - MEM_IDLE -> MEM_WAIT when dmem_req_Mem & !dmem_ready_Mem; timeout counter=1.
  - A same-cycle ready gives zero stall and the FSM stays in MEM_IDLE.
  - MEM_WAIT -> MEM_IDLE when dmem_ready_Mem. The stall drops in that same cycle and all registers advance on that edge.
  - MEM_WAIT with !dmem_ready_Mem: counter++. When the counter reaches MEM_TIMEOUT -> MEM_ERR.
  - MEM_ERR: mem_err=1; pipeline frozen; leaves only via reset.
  - A ready arriving on the timeout cycle wins and the FSM goes to MEM_IDLE.
- mem_wait = (state==MEM_WAIT), registered state decode.
- stall_cycles: +1 on each edge where any of {mem_stall, load_use without branch} held; saturates at all-ones.
- Mid-operation reset: immediate return to reset values. Outstanding memory handshakes are abandoned; the memory side must also be reset.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - enum mem_state_t {MEM_IDLE, MEM_WAIT, MEM_ERR}.
  - struct stage_ctrl_t {en_PC, en_IFID, en_IDEX, en_ExMem, en_MemWB, flush_IFID, flush_IDEX}.
  - REG_ZERO=5'd0.
- One sub-module: mem_wait_fsm, which owns the state, the timeout counter and mem_err, and outputs mem_stall/mem_wait.
- Hazard priority logic and stall_cycles stay in the top level.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (rs1_used=1) -> one cycle of en_PC=en_IFID=0, flush_IDEX=1; next cycle all en=1; stall_cycles=1.
- Hazard on x0, plus unused source: Rd_addr_EX=0 with MemRead_EX=1 -> no stall. Rd=x7 matching rs2 with rs2_used_ID=0 -> no stall.
- Branch and load-use in the same cycle: branch_taken_EX=1 together with load_use conditions -> flush_IFID=flush_IDEX=1, en_PC=1, stall_cycles unchanged.
- Memory wait:
  - dmem_req=1 with ready low for 3 cycles -> all en=0 for 3 cycles; mem_wait high on cycles 2–3.
  - Ready on cycle 4 -> en=1 that cycle and FSM=MEM_IDLE; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, ready never asserted -> MEM_ERR after the 4th wait edge; mem_err=1; pipeline frozen; rstn_Stall low -> mem_err=0, en=1 asynchronously.
- Deferred branch: branch_taken_EX=1 during MEM_WAIT -> no flush while stalled; flushes assert in the release cycle (ready=1); stall_cycles saturates at 0xFFFF under prolonged stall.
